// File: rtl/desk_queue_scheduler.sv
// Two-attendant reception desk scheduler: in-order query queue, A/B routing, per-attendant service timers.
// Accept-to-grant latency is 2 edges minimum; req_ready depends only on the registered occupancy.
module desk_queue_scheduler #(
  parameter int DEPTH          = 4,
  parameter int SERVICE_CYCLES = 15,
  parameter int TICKET_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [1:0]              req_query,
  output logic                    req_ready,
  output logic [TICKET_W-1:0]     req_ticket,
  output logic                    grant_valid,
  output logic [1:0]              grant_msg,
  output logic [TICKET_W-1:0]     grant_ticket,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic                    done_a,
  output logic                    done_b,
  output logic [$clog2(DEPTH):0]  queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TICKET_W + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    SVC     = 8'(SERVICE_CYCLES);

  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [TICKET_W-1:0] ticket;
  logic [7:0]          cnt_a, cnt_b;
  logic [EW-1:0]       head;
  logic                accept, dispatch, pick_a, pick_b, free_a, free_b;

  assign req_ready   = (count < DEPTH_C);
  assign req_ticket  = ticket;
  assign queue_count = count;
  assign busy_a      = (cnt_a != 8'd0);
  assign busy_b      = (cnt_b != 8'd0);
  assign done_a      = (cnt_a == 8'd1);
  assign done_b      = (cnt_b == 8'd1);
  assign accept      = req_valid && req_ready;
  assign dispatch    = pick_a || pick_b;

  // Only the head is considered; a blocked head stalls everything behind it.
  always_comb begin
    head   = mem[rd_ptr];
    free_a = (cnt_a == 8'd0);
    free_b = (cnt_b == 8'd0);
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (count != '0) begin
      case (head[EW-1:TICKET_W])
        2'b00:   pick_a = free_a;
        2'b11:   pick_b = free_b;
        default: begin
          pick_a = free_a;
          pick_b = !free_a && free_b;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {req_query, ticket};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ticket       <= '0;
      cnt_a        <= 8'd0;
      cnt_b        <= 8'd0;
      grant_valid  <= 1'b0;
      grant_msg    <= 2'b00;
      grant_ticket <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        ticket <= ticket + 1'b1;
      end
      if (dispatch) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pick_a)      cnt_a <= SVC;
      else if (busy_a) cnt_a <= cnt_a - 8'd1;
      if (pick_b)      cnt_b <= SVC;
      else if (busy_b) cnt_b <= cnt_b - 8'd1;
      grant_valid  <= dispatch;
      grant_msg    <= {pick_b, pick_a};
      grant_ticket <= dispatch ? head[TICKET_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_desk_queue_scheduler.sv
// Directed bench for desk_queue_scheduler with hand-computed expectations.
module tb_desk_queue_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_query = 2'b00;
  logic       req_ready;
  logic [3:0] req_ticket;
  logic       grant_valid;
  logic [1:0] grant_msg;
  logic [3:0] grant_ticket;
  logic       busy_a, busy_b, done_a, done_b;
  logic [2:0] queue_count;

  int nvec = 0;
  int nerr = 0;

  desk_queue_scheduler #(.DEPTH(4), .SERVICE_CYCLES(15), .TICKET_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_query(req_query),
    .req_ready(req_ready), .req_ticket(req_ticket), .grant_valid(grant_valid),
    .grant_msg(grant_msg), .grant_ticket(grant_ticket), .busy_a(busy_a),
    .busy_b(busy_b), .done_a(done_a), .done_b(done_b), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, int'(req_ready), 1);
    chk({tag, "_ticket"}, int'(req_ticket), 0);
    chk({tag, "_gvalid"}, int'(grant_valid), 0);
    chk({tag, "_gmsg"}, int'(grant_msg), 0);
    chk({tag, "_gticket"}, int'(grant_ticket), 0);
    chk({tag, "_busy_a"}, int'(busy_a), 0);
    chk({tag, "_busy_b"}, int'(busy_b), 0);
    chk({tag, "_done_a"}, int'(done_a), 0);
    chk({tag, "_done_b"}, int'(done_b), 0);
    chk({tag, "_count"}, int'(queue_count), 0);
  endtask

  initial begin
    int n, done_at, done_cyc, gcyc, found, a_idle, prev_ready, ng, nacc, ngr, flag;

    // 1: single query to A, service window length and done position
    #1;
    check_reset("por");
    #1 rst = 1'b0;
    req_valid = 1'b1; req_query = 2'b01;
    chk("t1_ticket0", int'(req_ticket), 0);
    tick;
    req_valid = 1'b0;
    chk("t1_count1", int'(queue_count), 1);
    chk("t1_no_bypass", int'(grant_valid), 0);
    tick;
    chk("t1_gvalid", int'(grant_valid), 1);
    chk("t1_gmsg", int'(grant_msg), 1);
    chk("t1_gticket", int'(grant_ticket), 0);
    chk("t1_count0", int'(queue_count), 0);
    n = 0; done_at = 0;
    while (busy_a && n < 100) begin
      n++;
      if (done_a) done_at = n;
      if (n == 2) chk("t1_gpulse", int'(grant_valid), 0);
      tick;
    end
    chk("t1_busy_len", n, 15);
    chk("t1_done_at", done_at, 15);
    chk("t1_done_clear", int'(done_a), 0);

    // 2: 01,10,00 -> A, B, then A again after one idle cycle
    do_reset;
    req_valid = 1'b1; req_query = 2'b01;
    tick;
    req_query = 2'b10;
    tick;
    chk("t2_g0_msg", int'(grant_msg), 1);
    chk("t2_g0_ticket", int'(grant_ticket), 0);
    req_query = 2'b00;
    tick;
    req_valid = 1'b0;
    chk("t2_g1_msg", int'(grant_msg), 2);
    chk("t2_g1_ticket", int'(grant_ticket), 1);
    chk("t2_busy_b", int'(busy_b), 1);
    chk("t2_count", int'(queue_count), 1);
    tick;
    done_cyc = -100; gcyc = -1;
    for (int c = 0; c < 60 && gcyc < 0; c++) begin
      if (done_a) done_cyc = c;
      if (grant_valid) begin
        gcyc = c;
        chk("t2_g2_msg", int'(grant_msg), 1);
        chk("t2_g2_ticket", int'(grant_ticket), 2);
      end else tick;
    end
    chk("t2_g2_seen", int'(gcyc >= 0), 1);
    chk("t2_regrant_gap", gcyc - done_cyc, 2);

    // 3: second 11 blocks a later 00 at the head
    do_reset;
    req_valid = 1'b1; req_query = 2'b11;
    tick;
    tick;
    chk("t3_g0_msg", int'(grant_msg), 2);
    chk("t3_g0_ticket", int'(grant_ticket), 0);
    req_query = 2'b00;
    tick;
    req_valid = 1'b0;
    chk("t3_blocked_gv", int'(grant_valid), 0);
    chk("t3_count", int'(queue_count), 2);
    found = 0; a_idle = 1;
    for (int c = 0; c < 60 && found == 0; c++) begin
      if (grant_valid) found = 1;
      else begin
        if (busy_a) a_idle = 0;
        tick;
      end
    end
    chk("t3_g1_seen", found, 1);
    chk("t3_g1_msg", int'(grant_msg), 2);
    chk("t3_g1_ticket", int'(grant_ticket), 1);
    chk("t3_a_idle", a_idle, 1);
    tick;
    chk("t3_g2_valid", int'(grant_valid), 1);
    chk("t3_g2_msg", int'(grant_msg), 1);
    chk("t3_g2_ticket", int'(grant_ticket), 2);

    // 4: fill to DEPTH behind a busy B with a held request
    do_reset;
    req_valid = 1'b1; req_query = 2'b11;
    for (int c = 0; c < 20 && queue_count != 3'd4; c++) tick;
    chk("t4_full", int'(queue_count), 4);
    chk("t4_ready_low", int'(req_ready), 0);
    chk("t4_held_ticket", int'(req_ticket), 5);
    found = 0; prev_ready = 1;
    for (int c = 0; c < 60 && found == 0; c++) begin
      if (grant_valid) found = 1;
      else begin
        prev_ready = int'(req_ready);
        tick;
      end
    end
    chk("t4_pop_seen", found, 1);
    chk("t4_pop_ticket", int'(grant_ticket), 1);
    chk("t4_ready_at_pop", prev_ready, 0);
    chk("t4_ready_after", int'(req_ready), 1);
    chk("t4_count3", int'(queue_count), 3);
    tick;
    req_valid = 1'b0;
    chk("t4_refill", int'(queue_count), 4);
    chk("t4_next_ticket", int'(req_ticket), 6);
    ng = 0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      tick;
      if (grant_valid) begin
        chk("t4_drain_ticket", int'(grant_ticket), 2 + ng);
        ng++;
      end
    end
    chk("t4_drain_n", ng, 4);
    chk("t4_empty", int'(queue_count), 0);

    // 5: 17 queries, ticket wrap and in-order grants
    do_reset;
    req_query = 2'b01;
    nacc = 0; ngr = 0;
    for (int c = 0; c < 1000 && ngr < 17; c++) begin
      if (grant_valid) begin
        chk("t5_grant_ticket", int'(grant_ticket), ngr % 16);
        ngr++;
      end
      req_valid = (nacc < 17);
      if (req_valid && req_ready) begin
        chk("t5_acc_ticket", int'(req_ticket), nacc % 16);
        nacc++;
      end
      tick;
    end
    req_valid = 1'b0;
    chk("t5_grants", ngr, 17);

    // 6: asynchronous reset mid-service
    do_reset;
    req_valid = 1'b1; req_query = 2'b00;
    tick; tick; tick; tick;
    req_valid = 1'b0;
    tick; tick;
    chk("t6_busy_a", int'(busy_a), 1);
    chk("t6_count3", int'(queue_count), 3);
    #2 rst = 1'b1;
    #1;
    check_reset("t6_async");
    @(posedge clk); #1;
    rst = 1'b0;
    flag = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_a || busy_a || grant_valid) flag = 1;
      tick;
    end
    chk("t6_no_done", flag, 0);
    req_valid = 1'b1; req_query = 2'b01;
    chk("t6_ticket0", int'(req_ticket), 0);
    tick;
    req_valid = 1'b0;
    tick;
    chk("t6_gvalid", int'(grant_valid), 1);
    chk("t6_gticket", int'(grant_ticket), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/desk_queue_scheduler.md
# desk_queue_scheduler

Front-end scheduler for the two-attendant reception desk. It accepts visitor queries over a valid/ready handshake and holds them in an in-order queue. Each query is dispatched to attendant A or B under the desk routing rules, and the block times each attendant's service window. It replaces the edge-triggered `start` strobe with a clocked, back-pressured request path, and it issues each visitor a wrapping ticket number.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- SERVICE_CYCLES, 15: cycles an attendant stays busy per grant; range 1..255.
- TICKET_W, 4: ticket number width; tickets wrap modulo 2^TICKET_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  query present.
- req_query  in  2  query type: 00 A-only, 01/10 A-preferred, 11 B-only.
- req_ready  out  1  queue can accept.
- req_ticket  out  TICKET_W  ticket assigned to the query accepted this cycle.
- grant_valid  out  1  one-cycle dispatch pulse.
- grant_msg  out  2  01 = attendant A, 10 = attendant B; 00 when grant_valid=0.
- grant_ticket  out  TICKET_W  ticket of the dispatched query.
- busy_a, busy_b  out  1  attendant in service.
- done_a, done_b  out  1  one-cycle pulse on the last busy cycle.
- queue_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Accept:
  - A query is accepted on a rising edge with req_valid && req_ready.
  - req_ready = (queue_count < DEPTH); it does not depend on a same-cycle dispatch.
  - The entry stores {query, ticket}; the ticket counter then increments, wrapping from 2^TICKET_W-1 to 0.
  - req_ticket shows the current counter value combinationally.
- Queue: circular FIFO with read/write pointers, in-order and head-only (head-of-line blocking is intended).
- Eligibility of the head entry:
  - 00: A free.
  - 11: B free.
  - 01/10: A free, else B free. A wins when both are free.
  - A server is free when its counter is 0.
- Dispatch, on an edge where queue non-empty and head eligible:
  - Pop the head.
  - Load the chosen server counter with SERVICE_CYCLES.
  - Register grant_valid=1, grant_msg and grant_ticket for the following cycle.
  - At most one dispatch per cycle.
- Service timer:
  - Each non-zero counter decrements by 1 per edge.
  - busy_x = (cnt_x != 0).
  - done_x = (cnt_x == 1).
  - A server becomes eligible on the edge after its counter reads 0.
- Simultaneous accept and dispatch in one edge: both take effect; queue_count is unchanged.
- Ineligible head: the entry stays put; no grant is issued and nothing is dropped.
- Reset:
  - Effective immediately, mid-service included.
  - Clears the queue, pointers, ticket counter and both timers.
  - Outputs after reset: req_ready=1, req_ticket=0, grant_valid=0, grant_msg=00, grant_ticket=0, busy_*=0, done_*=0, queue_count=0.
  - In-flight service is abandoned without a done pulse.

## Timing
- Accept-to-grant, with an empty queue and a free server:
  - Query accepted at edge E0 is visible in the queue after E0.
  - Dispatch happens at E1; grant_valid is high in the cycle after E1.
  - Minimum latency is 2 edges; there is no bypass.
- busy_x rises in the same cycle as grant_valid and stays high for exactly SERVICE_CYCLES cycles.
- done_x is high in the final busy cycle.
- The next grant to the same server can occur at the edge ending its last busy cycle +1, giving a gap of 1 idle cycle.
- Full queue: req_ready is low for the whole cycle, even if a dispatch pops at that cycle's edge. It rises one cycle after the pop.
- queue_count, req_ready and busy_x are registered or derived from registers; no combinational path runs from req_valid to req_ready.

## Test plan
1. Reset, then enqueue query 01 → ticket 0; grant_msg=01, grant_ticket=0 two edges later; busy_a high for exactly 15 cycles; done_a in cycle 15.
2. Enqueue 01, 10, 00 back-to-back with both attendants idle:
   - First query → A.
   - Second → B.
   - Third waits until A is free, then → A with ticket 2, one cycle after done_a.
3. Enqueue 11, 11 → first → B; the second holds the head and blocks a later 00 even though A is idle; the 00 is granted only after the second 11 dispatches.
4. Keep B busy, hold req_valid with query 11:
   - queue_count reaches 4 and req_ready drops.
   - The held request is accepted one cycle after the next pop.
   - No entry is lost or duplicated.
5. Enqueue 17 queries → tickets 0..15, then 0; grant_ticket order matches acceptance order.
6. Assert rst mid-service (busy_a=1, queue_count=3) → all outputs at reset values the same cycle with no clock needed; no done_a pulse; the next accepted query gets ticket 0.
